// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared widths, FSM state codes and redirect-source codes for the fetch-PC redirect controller.
// The `PC_WIDTH/`JUMP_WIDTH defines live here so every file of the block sees one definition.
`ifndef PC_REDIRECT_CTRL_DEFINES
`define PC_REDIRECT_CTRL_DEFINES
`define PC_WIDTH   32
`define JUMP_WIDTH 26
`endif

package pc_redirect_ctrl_pkg;

    typedef enum logic {
        PR_RUN  = 1'b0,
        PR_PEND = 1'b1
    } pr_state_e;

    typedef enum logic [1:0] {
        PR_SRC_NONE = 2'd0,
        PR_SRC_ID   = 2'd1,
        PR_SRC_EX   = 2'd2
    } pr_src_e;

    function automatic logic [31:0] pr_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pr_target_calc.sv
// Combinational ID-stage jump target and JAL return-address generation.
// JR beats JAL beats J; J and JAL share the pseudo-direct target.
module pr_target_calc
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = `PC_WIDTH,
    parameter int JUMP_WIDTH = `JUMP_WIDTH
) (
    input  logic [PC_WIDTH-1:0]   id_pc_i,
    input  logic                  jal_i,
    input  logic                  jr_i,
    input  logic [JUMP_WIDTH-1:0] jump_addr_i,
    input  logic [PC_WIDTH-1:0]   jr_addr_i,
    output logic [PC_WIDTH-1:0]   id_tgt_o,
    output logic [PC_WIDTH-1:0]   ra_o,
    output logic                  is_jal_o
);

    logic [PC_WIDTH-1:0] pc4;
    logic [PC_WIDTH-1:0] jmp_tgt;

    // Add wraps modulo 2^PC_WIDTH; the region bits come from the delay-slot-free PC+4.
    assign pc4      = id_pc_i + PC_WIDTH'(4);
    assign jmp_tgt  = {pc4[PC_WIDTH-1:JUMP_WIDTH+2], jump_addr_i, 2'b00};
    assign id_tgt_o = jr_i ? jr_addr_i : jmp_tgt;
    assign ra_o     = pc4;
    assign is_jal_o = jal_i & ~jr_i;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC owner: picks one redirect per cycle (EX branch > ID jump > PC+4), parks redirects seen under stall.
// Optional perf counters when PR_PERF_CNT_EN is defined.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int                 PC_WIDTH   = `PC_WIDTH,
    parameter int                 JUMP_WIDTH = `JUMP_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  pr_i_clk,
    input  logic                  pr_i_rst,
    input  logic                  pr_i_stall,
    input  logic                  pr_i_id_valid,
    input  logic [PC_WIDTH-1:0]   pr_i_id_pc,
    input  logic                  pr_i_j,
    input  logic                  pr_i_jal,
    input  logic                  pr_i_jr,
    input  logic [JUMP_WIDTH-1:0] pr_i_jump_addr,
    input  logic [PC_WIDTH-1:0]   pr_i_jr_addr,
    input  logic                  pr_i_ex_br_taken,
    input  logic [PC_WIDTH-1:0]   pr_i_ex_br_target,
    output logic [PC_WIDTH-1:0]   pr_o_pc,
    output logic                  pr_o_if_flush,
    output logic                  pr_o_id_flush,
    output logic [PC_WIDTH-1:0]   pr_o_ra,
    output logic                  pr_o_ra_we
`ifdef PR_PERF_CNT_EN
    ,
    output logic [31:0]           pr_o_redir_cnt,
    output logic [31:0]           pr_o_stall_cnt
`endif
);

    pr_state_e           state_q, state_d;
    pr_src_e             pend_src_q, pend_src_d;
    logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    logic [PC_WIDTH-1:0] id_tgt;
    logic                id_is_jal;
    logic                id_req;
    logic                redir_apply;

    pr_target_calc #(
        .PC_WIDTH   (PC_WIDTH),
        .JUMP_WIDTH (JUMP_WIDTH)
    ) u_target_calc (
        .id_pc_i     (pr_i_id_pc),
        .jal_i       (pr_i_jal),
        .jr_i        (pr_i_jr),
        .jump_addr_i (pr_i_jump_addr),
        .jr_addr_i   (pr_i_jr_addr),
        .id_tgt_o    (id_tgt),
        .ra_o        (pr_o_ra),
        .is_jal_o    (id_is_jal)
    );

    assign id_req = pr_i_id_valid & (pr_i_j | pr_i_jal | pr_i_jr);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_src_d    = pend_src_q;
        pend_tgt_d    = pend_tgt_q;
        pr_o_if_flush = 1'b0;
        pr_o_id_flush = 1'b0;
        pr_o_ra_we    = 1'b0;
        redir_apply   = 1'b0;

        case (state_q)
            PR_RUN: begin
                if (!pr_i_stall) begin
                    if (pr_i_ex_br_taken) begin
                        pc_d          = pr_i_ex_br_target;
                        pr_o_if_flush = 1'b1;
                        pr_o_id_flush = 1'b1;
                        redir_apply   = 1'b1;
                    end else if (id_req) begin
                        pc_d          = id_tgt;
                        pr_o_if_flush = 1'b1;
                        pr_o_ra_we    = id_is_jal;
                        redir_apply   = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_WIDTH'(4);
                    end
                end else if (pr_i_ex_br_taken) begin
                    pend_src_d = PR_SRC_EX;
                    pend_tgt_d = pr_i_ex_br_target;
                    state_d    = PR_PEND;
                end else if (id_req) begin
                    // JAL link write happens at acceptance, so the held copy never writes again.
                    pend_src_d = PR_SRC_ID;
                    pend_tgt_d = id_tgt;
                    pr_o_ra_we = id_is_jal;
                    state_d    = PR_PEND;
                end
            end
            PR_PEND: begin
                if (pr_i_stall) begin
                    if (pr_i_ex_br_taken && (pend_src_q == PR_SRC_ID)) begin
                        pend_src_d = PR_SRC_EX;
                        pend_tgt_d = pr_i_ex_br_target;
                    end
                end else begin
                    state_d       = PR_RUN;
                    pend_src_d    = PR_SRC_NONE;
                    pr_o_if_flush = 1'b1;
                    redir_apply   = 1'b1;
                    if (pr_i_ex_br_taken) begin
                        pc_d          = pr_i_ex_br_target;
                        pr_o_id_flush = 1'b1;
                    end else begin
                        pc_d          = pend_tgt_q;
                        pr_o_id_flush = (pend_src_q == PR_SRC_EX);
                    end
                end
            end
            default: begin
                state_d    = PR_RUN;
                pend_src_d = PR_SRC_NONE;
            end
        endcase
    end

    always_ff @(posedge pr_i_clk) begin
        if (pr_i_rst) begin
            state_q    <= PR_RUN;
            pc_q       <= RESET_PC;
            pend_src_q <= PR_SRC_NONE;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pr_o_pc = pc_q;

`ifdef PR_PERF_CNT_EN
    logic [31:0] redir_cnt_q, stall_cnt_q;

    always_ff @(posedge pr_i_clk) begin
        if (pr_i_rst) begin
            redir_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (redir_apply) redir_cnt_q <= pr_sat_inc(redir_cnt_q);
            if (pr_i_stall)  stall_cnt_q <= pr_sat_inc(stall_cnt_q);
        end
    end

    assign pr_o_redir_cnt = redir_cnt_q;
    assign pr_o_stall_cnt = stall_cnt_q;
`else
    logic unused_apply;
    assign unused_apply = redir_apply;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: sequential fetch, jump/branch priority, stall parking, reset.
module tb_pc_redirect_ctrl;
    import pc_redirect_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        j, jal, jr;
    logic [25:0] jump_addr;
    logic [31:0] jr_addr;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] pc;
    logic        if_flush, id_flush;
    logic [31:0] ra;
    logic        ra_we;
`ifdef PR_PERF_CNT_EN
    logic [31:0] redir_cnt, stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pc_redirect_ctrl dut (
        .pr_i_clk          (clk),
        .pr_i_rst          (rst),
        .pr_i_stall        (stall),
        .pr_i_id_valid     (id_valid),
        .pr_i_id_pc        (id_pc),
        .pr_i_j            (j),
        .pr_i_jal          (jal),
        .pr_i_jr           (jr),
        .pr_i_jump_addr    (jump_addr),
        .pr_i_jr_addr      (jr_addr),
        .pr_i_ex_br_taken  (ex_taken),
        .pr_i_ex_br_target (ex_target),
        .pr_o_pc           (pc),
        .pr_o_if_flush     (if_flush),
        .pr_o_id_flush     (id_flush),
        .pr_o_ra           (ra),
        .pr_o_ra_we        (ra_we)
`ifdef PR_PERF_CNT_EN
        ,
        .pr_o_redir_cnt    (redir_cnt),
        .pr_o_stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall = 0; id_valid = 0; id_pc = 0; j = 0; jal = 0; jr = 0;
        jump_addr = 0; jr_addr = 0; ex_taken = 0; ex_target = 0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1;
        tick(); tick();
        rst = 0;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        @(negedge clk);
        total++; if ({if_flush, id_flush, ra_we} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b exp=000", {if_flush, id_flush, ra_we}); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++; if (pc !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, 32'(4 * i)); end
            @(negedge clk);
            total++; if ({if_flush, id_flush} !== 2'b00) begin bad++; $display("FAIL seq_flush%0d got=%b exp=00", i, {if_flush, id_flush}); end
        end
        tick();
    endtask

    // pc = 0x10 on entry
    task automatic test_jal();
        id_valid = 1; jal = 1; id_pc = 32'h100; jump_addr = 26'h40;
        @(negedge clk);
        total++; if (ra !== 32'h104) begin bad++; $display("FAIL jal_ra got=%h exp=%h", ra, 32'h104); end
        total++; if ({ra_we, if_flush, id_flush} !== 3'b110) begin bad++; $display("FAIL jal_strobes got=%b exp=110", {ra_we, if_flush, id_flush}); end
        tick();
        clear_in();
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL jal_pc got=%h exp=%h", pc, 32'h100); end
        @(negedge clk);
        total++; if ({ra_we, if_flush} !== 2'b00) begin bad++; $display("FAIL jal_pulse got=%b exp=00", {ra_we, if_flush}); end
        tick();
        total++; if (pc !== 32'h104) begin bad++; $display("FAIL jal_next got=%h exp=%h", pc, 32'h104); end
    endtask

    task automatic test_priority();
        ex_taken = 1; ex_target = 32'h200;
        id_valid = 1; jr = 1; jr_addr = 32'h300; id_pc = 32'h104;
        @(negedge clk);
        total++; if ({if_flush, id_flush, ra_we} !== 3'b110) begin bad++; $display("FAIL prio_strobes got=%b exp=110", {if_flush, id_flush, ra_we}); end
        tick();
        clear_in();
        total++; if (pc !== 32'h200) begin bad++; $display("FAIL prio_pc got=%h exp=%h", pc, 32'h200); end
    endtask

    task automatic test_id_priority();
        id_valid = 1; j = 1; jal = 1; jr = 1; jr_addr = 32'h340; jump_addr = 26'h3;
        id_pc = 32'h200;
        @(negedge clk);
        total++; if ({if_flush, id_flush, ra_we} !== 3'b100) begin bad++; $display("FAIL jr_prio_strobes got=%b exp=100", {if_flush, id_flush, ra_we}); end
        tick();
        clear_in();
        total++; if (pc !== 32'h340) begin bad++; $display("FAIL jr_prio_pc got=%h exp=%h", pc, 32'h340); end
    endtask

    task automatic test_stall_pend();
        stall = 1; id_valid = 1; j = 1; jump_addr = 26'h20; id_pc = 32'h33C;
        @(negedge clk);
        total++; if ({if_flush, id_flush, ra_we} !== 3'b000) begin bad++; $display("FAIL stall_strobes got=%b exp=000", {if_flush, id_flush, ra_we}); end
        tick();
        j = 0; id_valid = 0;
        total++; if (dut.state_q !== PR_PEND) begin bad++; $display("FAIL stall_state got=%0d exp=%0d", dut.state_q, PR_PEND); end
        for (int i = 0; i < 2; i++) begin
            total++; if (pc !== 32'h340) begin bad++; $display("FAIL stall_frozen%0d got=%h exp=%h", i, pc, 32'h340); end
            tick();
        end
        total++; if (pc !== 32'h340) begin bad++; $display("FAIL stall_frozen2 got=%h exp=%h", pc, 32'h340); end
        stall = 0;
        @(negedge clk);
        total++; if ({if_flush, id_flush} !== 2'b10) begin bad++; $display("FAIL pend_apply_flush got=%b exp=10", {if_flush, id_flush}); end
        tick();
        total++; if (pc !== 32'h80) begin bad++; $display("FAIL pend_apply_pc got=%h exp=%h", pc, 32'h80); end
        total++; if (dut.state_q !== PR_RUN) begin bad++; $display("FAIL pend_back_run got=%0d exp=%0d", dut.state_q, PR_RUN); end
    endtask

    // pc = 0x80 on entry
    task automatic test_pend_ex();
        stall = 1; id_valid = 1; jal = 1; id_pc = 32'h300; jump_addr = 26'h100;
        @(negedge clk);
        total++; if ({ra_we, if_flush} !== 2'b10 || ra !== 32'h304) begin bad++; $display("FAIL stall_jal got we=%b fl=%b ra=%h exp we=1 fl=0 ra=304", ra_we, if_flush, ra); end
        tick();
        @(negedge clk);
        total++; if (ra_we !== 1'b0) begin bad++; $display("FAIL jal_once got=%b exp=0", ra_we); end
        tick();
        clear_in();
        ex_taken = 1; ex_target = 32'h500;
        @(negedge clk);
        total++; if ({if_flush, id_flush} !== 2'b11) begin bad++; $display("FAIL pend_ex_flush got=%b exp=11", {if_flush, id_flush}); end
        tick();
        clear_in();
        total++; if (pc !== 32'h500) begin bad++; $display("FAIL pend_ex_pc got=%h exp=%h", pc, 32'h500); end
    endtask

    task automatic test_pend_overwrite();
        stall = 1; id_valid = 1; j = 1; id_pc = 32'h500; jump_addr = 26'h30;
        tick();
        clear_in();
        stall = 1; ex_taken = 1; ex_target = 32'h600;
        tick();
        clear_in();
        total++; if (pc !== 32'h500) begin bad++; $display("FAIL ovw_frozen got=%h exp=%h", pc, 32'h500); end
        @(negedge clk);
        total++; if ({if_flush, id_flush} !== 2'b11) begin bad++; $display("FAIL ovw_flush got=%b exp=11", {if_flush, id_flush}); end
        tick();
        total++; if (pc !== 32'h600) begin bad++; $display("FAIL ovw_pc got=%h exp=%h", pc, 32'h600); end
    endtask

    task automatic test_wrap();
        id_valid = 1; jal = 1; id_pc = 32'hFFFF_FFFC; jump_addr = 26'h3FF_FFFF;
        @(negedge clk);
        total++; if (ra !== 32'h0 || ra_we !== 1'b1) begin bad++; $display("FAIL wrap_ra got=%h we=%b exp=00000000 we=1", ra, ra_we); end
        tick();
        clear_in();
        total++; if (pc !== 32'h0FFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0FFF_FFFC); end
    endtask

    task automatic test_reset_pend();
        stall = 1; id_valid = 1; j = 1; jump_addr = 26'h20; id_pc = 32'h0;
        tick();
        total++; if (dut.state_q !== PR_PEND) begin bad++; $display("FAIL rstp_state got=%0d exp=%0d", dut.state_q, PR_PEND); end
        rst = 1;
        tick();
        rst = 0;
        clear_in();
        total++; if (pc !== 32'h0 || dut.state_q !== PR_RUN) begin bad++; $display("FAIL rstp_pc got=%h st=%0d exp=0 st=0", pc, dut.state_q); end
`ifdef PR_PERF_CNT_EN
        total++; if (redir_cnt !== 32'h0 || stall_cnt !== 32'h0) begin bad++; $display("FAIL rstp_cnt got=%h/%h exp=0/0", redir_cnt, stall_cnt); end
`endif
        @(negedge clk);
        total++; if ({if_flush, id_flush} !== 2'b00) begin bad++; $display("FAIL rstp_flush got=%b exp=00", {if_flush, id_flush}); end
        tick();
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL rstp_seq got=%h exp=%h", pc, 32'h4); end
    endtask

    initial begin
        rst = 1;
        clear_in();
        test_reset();
        test_jal();
        test_priority();
        test_id_priority();
        test_stall_pend();
        test_pend_ex();
        test_pend_overwrite();
        test_wrap();
        test_reset_pend();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
